token_tx_seq: RTL and testbench
===============================

Name: token_tx_seq

Overview:
- Sequencer that builds a USB token packet (SYNC, PID, ADDR/ENDP, CRC5) as a serial bitstream for the downstream bit-stuff/NRZI stage.
- Generates SYNC and PID bits itself.
- Feeds the 11 ADDR/ENDP bits through the existing CRC5 inserter, then forwards the 5 CRC bits that inserter appends.
- Sits between the packet-level control logic and the crc/bit-stuffer chain, and owns the CRC block's recving input.

Parameters:
SYNC_PAT, 8'h80, SYNC bits; bit 0 is transmitted first.
FIELD_LEN, 11, number of ADDR+ENDP bits routed through the CRC.
CRC_LEN, 5, number of CRC bits forwarded after the field.

Ports:
clk  in  1  system clock
rst_L  in  1  reset; asynchronous, active-low
start  in  1  one-cycle request to send a token; ignored while busy
pid  in  4  token PID, latched on accepted start
addr  in  7  device address, latched on accepted start
endp  in  4  endpoint, latched on accepted start
pause_out  in  1  downstream stall; no bit advances while high
outb  out  1  serial bit to downstream
sending  out  1  outb is valid
busy  out  1  packet in progress (state != IDLE)
done  out  1  one-cycle pulse after the last CRC bit is accepted
crc_inb  out  1  field bit to the CRC block
crc_recving  out  1  CRC block recving input
crc_outb  in  1  CRC block serial output
crc_sending  in  1  CRC block sending flag
crc_pause_in  in  1  CRC block is emitting its CRC and not consuming input

Behaviour:
- Reset: state IDLE, bit counter 0. Outputs outb, sending, busy, done, crc_inb and crc_recving are all 0. Latched pid/addr/endp are cleared to 0.
- Reset asserted mid-packet aborts immediately to IDLE, with outputs as above. No done pulse is generated.
- Accepted bit: sending && !pause_out. All counters and state advance only on an accepted bit. While pause_out is high, outb, crc_inb and crc_recving hold their values.
- Bit counter: 4 bits. It clears on every phase change and increments on each accepted bit.
- States: IDLE, SYNC, PID, FIELD, CRC, FIN.
  - IDLE: busy=0, sending=0. start=1 latches pid/addr/endp and sets next state SYNC. The first bit appears on outb in the cycle after start (latency 1).
  - SYNC: outb=SYNC_PAT[cnt], sending=1. After 8 accepted bits, go to PID.
  - PID: outb = {~pid, pid}[cnt], i.e. pid[0..3] then ~pid[0..3]. After 8 accepted bits, go to FIELD.
  - FIELD: crc_recving=1 and crc_inb = {endp, addr}[cnt], i.e. addr[0] first and endp[3] last. outb=crc_outb and sending=crc_sending (CRC pass-through). After FIELD_LEN accepted bits, go to CRC.
  - CRC: crc_recving=0, outb=crc_outb, sending=crc_sending. Count CRC_LEN accepted bits, then go to FIN.
  - CRC wait: if crc_sending=0 in CRC state, no bit is counted and the sequencer waits.
  - FIN: done=1 for exactly one cycle, busy=0, then go to IDLE.
- Total packet length is 8+8+FIELD_LEN+CRC_LEN = 32 accepted bits.
- Back-to-back packets: a start asserted in the same cycle as done (FIN) is ignored. A start in the next cycle is accepted.
- Start with pause_out high: the transition to SYNC still occurs, and bit 0 holds until the pause releases.
- crc_pause_in is a protocol check only. It must be 1 during CRC state while crc_sending=1, and 0 during FIELD. A violation sets an internal sticky error flag visible to the bench; output behaviour is otherwise unchanged.

Test Plan:
- Basic OUT token: start with pid=4'b0001, addr=7'h3A, endp=4'h1, pause_out=0, CRC stub echoing crc_inb in FIELD and driving pattern 1,0,1,1,0 in CRC. Required: outb sequence 00000001, 1000 0111, 0101110 1000, 10110; done pulses at cycle 33; busy high for cycles 1-32.
- Integrated real crc block: addr=7'h15, endp=4'hE. Required: the 5 trailing bits match a CRC5 reference model (spec vector 5'h17); crc_recving is high for exactly 11 accepted bits.
- Stall: pause_out held high for 3 cycles at SYNC bit 7, PID bit 2, FIELD bit 10 and CRC bit 0. Required: outb and crc_inb stay frozen, the bitstream is unchanged, and done is delayed by 12 cycles relative to the basic case.
- Start while busy: start pulsed at cycle 10, and again in the done cycle. Required: both are ignored, exactly one packet is sent, and pid/addr/endp stay at the first latched values.
- Reset mid-FIELD: rst_L low at field bit 5. Required: all outputs go to 0 asynchronously, no done pulse; a start issued after reset produces a complete, correct 32-bit packet.
- CRC handshake: crc_sending held 0 for 2 cycles at entry to CRC state. Required: no CRC bit is counted, and done still follows exactly 5 accepted CRC bits.

Source files
------------

// File: rtl/token_tx_seq.sv
// token_tx_seq: builds a USB token packet (SYNC, PID, ADDR/ENDP, CRC5) as a
// serial bitstream for the downstream bit-stuff/NRZI stage. SYNC and PID are
// generated locally. The 11 ADDR/ENDP bits are fed through the external CRC5
// inserter, and the output passes through whatever that block emits, including
// the 5 CRC bits it appends.
module token_tx_seq #(
  parameter logic [7:0] SYNC_PAT  = 8'h80, // bit 0 goes out first
  parameter int         FIELD_LEN = 11,    // ADDR (7) + ENDP (4) bits
  parameter int         CRC_LEN   = 5
) (
  input  logic       clk,
  input  logic       rst_L,
  input  logic       start,
  input  logic [3:0] pid,
  input  logic [6:0] addr,
  input  logic [3:0] endp,
  input  logic       pause_out,
  output logic       outb,
  output logic       sending,
  output logic       busy,
  output logic       done,
  output logic       crc_inb,
  output logic       crc_recving,
  input  logic       crc_outb,
  input  logic       crc_sending,
  input  logic       crc_pause_in
);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    PID,
    FIELD,
    CRC,
    FIN
  } state_e;

  localparam logic [3:0] LAST_SYNC  = 4'd7;
  localparam logic [3:0] LAST_PID   = 4'd7;
  localparam logic [3:0] LAST_FIELD = 4'(FIELD_LEN - 1);
  localparam logic [3:0] LAST_CRC   = 4'(CRC_LEN - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] pid_q, pid_d;
  logic [6:0] addr_q, addr_d;
  logic [3:0] endp_q, endp_d;

  logic outb_q, outb_d;
  logic sending_q, sending_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic crc_inb_q, crc_inb_d;
  logic crc_recving_q, crc_recving_d;
  logic proto_err_q, proto_err_d;   // sticky CRC handshake violation

  logic        pass_thru;
  logic        accept;
  logic [7:0]  pid_bits;
  logic [10:0] field_bits;

  // In FIELD and CRC the serial stream belongs to the CRC block; elsewhere it
  // comes from our own registered bit. Keying off state_q makes reset force
  // outb/sending low immediately.
  assign pass_thru = (state_q == FIELD) || (state_q == CRC);
  assign sending   = pass_thru ? crc_sending : sending_q;
  assign outb      = pass_thru ? crc_outb    : outb_q;
  assign accept    = sending && !pause_out;

  assign busy        = busy_q;
  assign done        = done_q;
  assign crc_inb     = crc_inb_q;
  assign crc_recving = crc_recving_q;

  // Next-state, counter, latch and registered-output decode.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    pid_d         = pid_q;
    addr_d        = addr_q;
    endp_d        = endp_q;
    proto_err_d   = proto_err_q;
    outb_d        = 1'b0;
    sending_d     = 1'b0;
    crc_inb_d     = 1'b0;
    crc_recving_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SYNC;
          cnt_d   = 4'd0;
          pid_d   = pid;
          addr_d  = addr;
          endp_d  = endp;
        end
      end
      SYNC: begin
        if (accept) begin
          if (cnt_q == LAST_SYNC) begin
            state_d = PID;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      PID: begin
        if (accept) begin
          if (cnt_q == LAST_PID) begin
            state_d = FIELD;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      FIELD: begin
        if (accept) begin
          if (cnt_q == LAST_FIELD) begin
            state_d = CRC;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      CRC: begin
        // While the CRC block drops crc_sending, accept stays low and we wait.
        if (accept) begin
          if (cnt_q == LAST_CRC) begin
            state_d = FIN;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      FIN: begin
        // A start arriving alongside done is dropped here on purpose.
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // The CRC block must not claim to be emitting while we still feed it, and
    // must claim it whenever it sends during the CRC phase.
    if ((state_q == FIELD) && crc_pause_in) begin
      proto_err_d = 1'b1;
    end
    if ((state_q == CRC) && crc_sending && !crc_pause_in) begin
      proto_err_d = 1'b1;
    end

    // Outputs are decoded from the next state so they are registered; a
    // paused cycle keeps state/cnt and therefore holds every output.
    pid_bits   = {~pid_d, pid_d};
    field_bits = {endp_d, addr_d};
    unique case (state_d)
      SYNC: begin
        outb_d    = SYNC_PAT[cnt_d[2:0]];
        sending_d = 1'b1;
      end
      PID: begin
        outb_d    = pid_bits[cnt_d[2:0]];
        sending_d = 1'b1;
      end
      FIELD: begin
        crc_inb_d     = field_bits[cnt_d];
        crc_recving_d = 1'b1;
      end
      default: ;
    endcase
    busy_d = (state_d == SYNC) || (state_d == PID) ||
             (state_d == FIELD) || (state_d == CRC);
    done_d = (state_d == FIN);
  end

  // State and output registers; reset aborts any packet without a done pulse.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      pid_q         <= 4'd0;
      addr_q        <= 7'd0;
      endp_q        <= 4'd0;
      outb_q        <= 1'b0;
      sending_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      crc_inb_q     <= 1'b0;
      crc_recving_q <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pid_q         <= pid_d;
      addr_q        <= addr_d;
      endp_q        <= endp_d;
      outb_q        <= outb_d;
      sending_q     <= sending_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      crc_inb_q     <= crc_inb_d;
      crc_recving_q <= crc_recving_d;
      proto_err_q   <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_token_tx_seq.sv
// Testbench for token_tx_seq: directed token packets against a behavioural
// CRC5 inserter that either echoes/plays a fixed pattern or computes the real
// USB CRC5. Expected streams are written out by hand in transmit order.
module tb_token_tx_seq;

  logic       clk;
  logic       rst_L;
  logic       start;
  logic [3:0] pid;
  logic [6:0] addr;
  logic [3:0] endp;
  logic       pause_out;
  logic       outb, sending, busy, done, crc_inb, crc_recving;
  logic       crc_outb, crc_sending, crc_pause_in;

  int tests_run;
  int tests_failed;

  localparam int         NCYC     = 70;
  localparam logic [4:0] STUB_PAT = 5'b10110;   // emitted left to right

  // Hand-written streams, first transmitted bit is the MSB.
  localparam logic [31:0] EXP_BASIC = 32'b00000001_10000111_01011101000_10110;
  localparam logic [31:0] EXP_REAL  = 32'b00000001_10010110_10101000111_10111;

  // CRC block model controls
  logic       crc_stub;
  logic       crc_hold;
  logic       model_clr;
  logic [4:0] crc_reg;
  int         field_seen;
  int         emit_idx;
  logic       emitting;
  logic       crc_fb;

  token_tx_seq dut (
    .clk          (clk),
    .rst_L        (rst_L),
    .start        (start),
    .pid          (pid),
    .addr         (addr),
    .endp         (endp),
    .pause_out    (pause_out),
    .outb         (outb),
    .sending      (sending),
    .busy         (busy),
    .done         (done),
    .crc_inb      (crc_inb),
    .crc_recving  (crc_recving),
    .crc_outb     (crc_outb),
    .crc_sending  (crc_sending),
    .crc_pause_in (crc_pause_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CRC block model: echoes the field bit while receiving, then emits 5 bits.
  assign emitting = (field_seen == 11) && (emit_idx < 5);
  assign crc_fb   = crc_inb ^ crc_reg[4];

  always_comb begin
    crc_sending  = 1'b0;
    crc_outb     = 1'b0;
    crc_pause_in = 1'b0;
    if (crc_recving) begin
      crc_sending = 1'b1;
      crc_outb    = crc_inb;
    end else if (emitting) begin
      crc_pause_in = 1'b1;
      crc_sending  = !crc_hold;
      crc_outb     = crc_stub ? STUB_PAT[3'(4 - emit_idx)] : ~crc_reg[3'(4 - emit_idx)];
    end
  end

  always @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      crc_reg    <= 5'h1f;
      field_seen <= 0;
      emit_idx   <= 0;
    end else if (model_clr) begin
      crc_reg    <= 5'h1f;
      field_seen <= 0;
      emit_idx   <= 0;
    end else begin
      if (crc_recving && !pause_out) begin
        field_seen <= field_seen + 1;
        crc_reg    <= {crc_reg[3:0], 1'b0} ^ (crc_fb ? 5'b00101 : 5'b00000);
      end
      if (emitting && crc_sending && !pause_out) begin
        emit_idx <= emit_idx + 1;
      end
    end
  end

  // Runs one packet (start at cycle 0) for NCYC cycles and reports what it saw.
  task automatic run_pkt(
    input  logic [3:0]  p,
    input  logic [6:0]  a,
    input  logic [3:0]  e,
    input  logic [31:0] stall_mask,
    input  bit          hold_crc,
    input  int          restart_a,
    input  int          restart_b,
    input  int          abort_bit,
    output logic [31:0] bits,
    output int          nbits,
    output int          done_cyc,
    output int          ndone,
    output int          busy_cyc,
    output int          busy_first,
    output int          recv_cnt,
    output int          freeze_err,
    output bit          abort_zero
  );
    logic [31:0] stalled;
    int   pause_left, hold_left;
    bit   held, aborted, prev_paused;
    logic prev_outb, prev_inb, prev_rcv;
    bits = '0; nbits = 0; done_cyc = -1; ndone = 0; busy_cyc = 0;
    busy_first = -1; recv_cnt = 0; freeze_err = 0; abort_zero = 1'b0;
    stalled = '0; pause_left = 0; hold_left = 0; held = 0; aborted = 0;
    prev_paused = 0; prev_outb = 0; prev_inb = 0; prev_rcv = 0;

    @(negedge clk);
    rst_L = 1'b1; start = 1'b0; pause_out = 1'b0; crc_hold = 1'b0;
    model_clr = 1'b1;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      model_clr = 1'b0;
      if (aborted) rst_L = 1'b1;
      if (cyc == 0) begin
        start = 1'b1; pid = p; addr = a; endp = e;
      end else begin
        start = (cyc == restart_a) || (cyc == restart_b);
        pid = 4'hF; addr = 7'h7F; endp = 4'hF;
      end
      if (busy === 1'b1 && nbits < 32 && stall_mask[nbits] && !stalled[nbits]) begin
        stalled[nbits] = 1'b1;
        pause_left = 3;
      end
      pause_out = (pause_left > 0);
      if (pause_left > 0) pause_left--;
      if (hold_crc && nbits == 27 && !held) begin
        held = 1;
        hold_left = 2;
      end
      crc_hold = (hold_left > 0);
      if (hold_left > 0) hold_left--;
      #1;
      if (abort_bit >= 0 && nbits == abort_bit && !aborted) begin
        rst_L = 1'b0;
        #1;
        abort_zero = ({outb, sending, busy, done, crc_inb, crc_recving} === 6'b0);
        aborted = 1;
      end
      if (prev_paused && (outb !== prev_outb || crc_inb !== prev_inb ||
                          crc_recving !== prev_rcv)) begin
        freeze_err++;
      end
      prev_paused = pause_out; prev_outb = outb; prev_inb = crc_inb; prev_rcv = crc_recving;
      if (busy === 1'b1) begin
        busy_cyc++;
        if (busy_first < 0) busy_first = cyc;
      end
      if (done === 1'b1) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (sending === 1'b1 && !pause_out) begin
        bits = {bits[30:0], outb};
        nbits++;
        if (crc_recving === 1'b1) recv_cnt++;
      end
    end
    start = 1'b0; pause_out = 1'b0; crc_hold = 1'b0;
  endtask

  task automatic test_reset();
    int busy_seen;
    rst_L = 1'b0; start = 1'b0; pause_out = 1'b0; pid = '0; addr = '0; endp = '0;
    crc_stub = 1'b1; crc_hold = 1'b0; model_clr = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({outb, sending, busy, done, crc_inb, crc_recving} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {outb, sending, busy, done, crc_inb, crc_recving});
    end
    tests_run++;
    if ({dut.pid_q, dut.addr_q, dut.endp_q} !== 15'd0) begin
      tests_failed++;
      $display("FAIL reset_latches: got %h expected 0", {dut.pid_q, dut.addr_q, dut.endp_q});
    end
    rst_L = 1'b1;
    busy_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy !== 1'b0 || sending !== 1'b0) busy_seen++;
    end
    tests_run++;
    if (busy_seen != 0) begin
      tests_failed++;
      $display("FAIL idle_no_start: got %0d busy cycles expected 0", busy_seen);
    end
  endtask

  task automatic test_basic();
    logic [31:0] bits; int nb, dc, nd, bc, bf, rc, fe; bit az;
    crc_stub = 1'b1;
    run_pkt(4'b0001, 7'h3A, 4'h1, 32'h0, 0, -1, -1, -1, bits, nb, dc, nd, bc, bf, rc, fe, az);
    tests_run++;
    if (bits !== EXP_BASIC || nb != 32) begin
      tests_failed++;
      $display("FAIL basic_stream: got %b (%0d bits) expected %b (32 bits)", bits, nb, EXP_BASIC);
    end
    tests_run++;
    if (dc != 33 || nd != 1) begin
      tests_failed++;
      $display("FAIL basic_done: got cycle %0d x%0d expected cycle 33 x1", dc, nd);
    end
    tests_run++;
    if (bf != 1 || bc != 32) begin
      tests_failed++;
      $display("FAIL basic_busy: got first %0d count %0d expected first 1 count 32", bf, bc);
    end
  endtask

  task automatic test_real_crc();
    logic [31:0] bits; int nb, dc, nd, bc, bf, rc, fe; bit az;
    crc_stub = 1'b0;
    run_pkt(4'b1001, 7'h15, 4'hE, 32'h0, 0, -1, -1, -1, bits, nb, dc, nd, bc, bf, rc, fe, az);
    crc_stub = 1'b1;
    tests_run++;
    if (bits[4:0] !== 5'h17) begin
      tests_failed++;
      $display("FAIL real_crc5: got %h expected 17", bits[4:0]);
    end
    tests_run++;
    if (bits !== EXP_REAL || nb != 32) begin
      tests_failed++;
      $display("FAIL real_stream: got %b (%0d bits) expected %b", bits, nb, EXP_REAL);
    end
    tests_run++;
    if (rc != 11) begin
      tests_failed++;
      $display("FAIL real_recving: got %0d accepted field bits expected 11", rc);
    end
    tests_run++;
    if (dc != 33) begin
      tests_failed++;
      $display("FAIL real_done: got cycle %0d expected 33", dc);
    end
  endtask

  task automatic test_stall();
    logic [31:0] bits; int nb, dc, nd, bc, bf, rc, fe; bit az;
    logic [31:0] mask;
    mask = (32'd1 << 7) | (32'd1 << 10) | (32'd1 << 26) | (32'd1 << 27);
    run_pkt(4'b0001, 7'h3A, 4'h1, mask, 0, -1, -1, -1, bits, nb, dc, nd, bc, bf, rc, fe, az);
    tests_run++;
    if (bits !== EXP_BASIC || nb != 32) begin
      tests_failed++;
      $display("FAIL stall_stream: got %b (%0d bits) expected %b", bits, nb, EXP_BASIC);
    end
    tests_run++;
    if (fe != 0) begin
      tests_failed++;
      $display("FAIL stall_freeze: got %0d changes while paused expected 0", fe);
    end
    tests_run++;
    if (dc != 45) begin
      tests_failed++;
      $display("FAIL stall_done: got cycle %0d expected 45", dc);
    end
  endtask

  task automatic test_start_busy();
    logic [31:0] bits; int nb, dc, nd, bc, bf, rc, fe; bit az;
    run_pkt(4'b0001, 7'h3A, 4'h1, 32'h0, 0, 10, 33, -1, bits, nb, dc, nd, bc, bf, rc, fe, az);
    tests_run++;
    if (bits !== EXP_BASIC || nb != 32) begin
      tests_failed++;
      $display("FAIL busy_stream: got %b (%0d bits) expected %b", bits, nb, EXP_BASIC);
    end
    tests_run++;
    if (nd != 1 || bc != 32 || dc != 33) begin
      tests_failed++;
      $display("FAIL busy_single_pkt: got done x%0d at %0d busy %0d expected x1 at 33 busy 32",
               nd, dc, bc);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] bits; int nb, dc, nd, bc, bf, rc, fe; bit az;
    run_pkt(4'b0001, 7'h3A, 4'h1, 32'h0, 0, -1, -1, 21, bits, nb, dc, nd, bc, bf, rc, fe, az);
    tests_run++;
    if (az !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid_outputs: got nonzero outputs expected all 0");
    end
    tests_run++;
    if (nd != 0 || nb != 21) begin
      tests_failed++;
      $display("FAIL rstmid_abort: got done x%0d bits %0d expected x0 bits 21", nd, nb);
    end
    run_pkt(4'b0001, 7'h3A, 4'h1, 32'h0, 0, -1, -1, -1, bits, nb, dc, nd, bc, bf, rc, fe, az);
    tests_run++;
    if (bits !== EXP_BASIC || nb != 32 || dc != 33) begin
      tests_failed++;
      $display("FAIL rstmid_recover: got %b (%0d bits) done %0d expected %b (32) done 33",
               bits, nb, dc, EXP_BASIC);
    end
  endtask

  task automatic test_crc_handshake();
    logic [31:0] bits; int nb, dc, nd, bc, bf, rc, fe; bit az;
    run_pkt(4'b0001, 7'h3A, 4'h1, 32'h0, 1, -1, -1, -1, bits, nb, dc, nd, bc, bf, rc, fe, az);
    tests_run++;
    if (bits !== EXP_BASIC || nb != 32) begin
      tests_failed++;
      $display("FAIL hs_stream: got %b (%0d bits) expected %b", bits, nb, EXP_BASIC);
    end
    tests_run++;
    if (dc != 35 || nd != 1) begin
      tests_failed++;
      $display("FAIL hs_done: got cycle %0d x%0d expected 35 x1", dc, nd);
    end
    tests_run++;
    if (dut.proto_err_q !== 1'b0) begin
      tests_failed++;
      $display("FAIL proto_err: got %b expected 0", dut.proto_err_q);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_real_crc();
    test_stall();
    test_start_busy();
    test_reset_mid();
    test_crc_handshake();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
